core_clock_req: RTL and testbench

//  Request side of the core clock gating scheme; drives the g_clk_*_req inputs of core_clock_ctrl.

---
 rtl/core_clock_pkg.sv | 24 ++
 rtl/core_clock_hold.sv | 30 +++
 rtl/core_clock_req.sv | 99 +++++++++
 tb/tb_core_clock_req.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/core_clock_pkg.sv
// Shared types for the core clock request logic: FSM state encoding and
// sub-domain indices used to order the per-domain hold counters.
package core_clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } core_clk_state_t;

  localparam int CLK_DOM_RF  = 0;
  localparam int CLK_DOM_PMP = 1;
  localparam int CLK_DOM_MUL = 2;
  localparam int CLK_DOM_NUM = 3;

  // One counter width serves both the idle hold-off and the wake count.
  function automatic int clk_cnt_w(input int idle, input int wake);
    int mx;
    mx = (idle > wake) ? idle : wake;
    return ($clog2(mx + 1) < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/core_clock_hold.sv
// Per-domain hold-off: keeps a sub-domain clock request up for IDLE_CYCLES
// after the last activity; freeze (SLEEP) forces the request low.
module core_clock_hold #(
  parameter int IDLE_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic f_clk,
  input  logic g_resetn,
  input  logic act,
  input  logic freeze,
  output logic req
);

  localparam logic [CNT_W-1:0] LP_IDLE = CNT_W'(IDLE_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_cnt <= LP_IDLE;
    end else if (!freeze) begin
      if (act)               r_cnt <= LP_IDLE;
      else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end
  end

  // Combinational on act so activity in a cycle clocks the edge that ends it.
  assign req = !freeze && (act || (r_cnt != '0));

endmodule

// File: rtl/core_clock_req.sv
// Core clock request generator: per-domain hold-off requests plus the
// RUN/DRAIN/SLEEP/WAKE sequencer that stops the core clock around WFI.
module core_clock_req
  import core_clock_pkg::*;
#(
  parameter logic CLK_GATE_EN = 1'b1,
  parameter int   IDLE_CYCLES = 4,
  parameter int   WAKE_CYCLES = 2
) (
  input  logic f_clk,
  input  logic g_resetn,
  input  logic sleep_req,
  output logic sleep_ack,
  input  logic wake_req,
  output logic wake_ack,
  input  logic rf_act,
  input  logic pmp_act,
  input  logic mul_act,
  output logic g_clk_req,
  output logic g_clk_rf_req,
  output logic g_clk_pmp_req,
  output logic g_clk_mul_req
);

  localparam int CNT_W = clk_cnt_w(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CNT_W-1:0] LP_WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  core_clk_state_t r_state, w_state_nx;
  logic [CNT_W-1:0] r_wake_cnt;
  logic             r_wake_ack;
  logic [CLK_DOM_NUM-1:0] w_act, w_sub_req;
  logic w_freeze, w_wake_done, w_core_req, w_sleep_ack;

  assign w_act[CLK_DOM_RF]  = rf_act;
  assign w_act[CLK_DOM_PMP] = pmp_act;
  assign w_act[CLK_DOM_MUL] = mul_act;

  assign w_freeze = (r_state == SLEEP);

  for (genvar d = 0; d < CLK_DOM_NUM; d++) begin : g_hold
    core_clock_hold #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .CNT_W      (CNT_W)
    ) u_hold (
      .f_clk   (f_clk),
      .g_resetn(g_resetn),
      .act     (w_act[d]),
      .freeze  (w_freeze),
      .req     (w_sub_req[d])
    );
  end

  assign w_wake_done = (r_wake_cnt == LP_WAKE_LAST);

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) r_state <= RUN;
    else           r_state <= w_state_nx;
  end

  // Outside SLEEP the ungated sub req is act | cnt!=0, so all-zero means drained.
  always_comb begin
    w_state_nx  = r_state;
    w_core_req  = 1'b1;
    w_sleep_ack = 1'b0;
    case (r_state)
      RUN:   if (sleep_req && !wake_req && !r_wake_ack) w_state_nx = DRAIN;
      DRAIN: begin
        if (wake_req)               w_state_nx = RUN;
        else if (w_sub_req == '0)   w_state_nx = SLEEP;
      end
      SLEEP: begin
        w_core_req  = 1'b0;
        w_sleep_ack = 1'b1;
        if (wake_req) w_state_nx = WAKE;
      end
      WAKE:  if (w_wake_done) w_state_nx = RUN;
      default: w_state_nx = RUN;
    endcase
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_wake_cnt <= '0;
      r_wake_ack <= 1'b0;
    end else begin
      r_wake_ack <= (r_state == WAKE) && w_wake_done;
      if ((r_state == WAKE) && !w_wake_done) r_wake_cnt <= r_wake_cnt + 1'b1;
      else                                   r_wake_cnt <= '0;
    end
  end

  assign sleep_ack     = w_sleep_ack;
  assign wake_ack      = r_wake_ack;
  assign g_clk_req     = !CLK_GATE_EN || w_core_req;
  assign g_clk_rf_req  = !CLK_GATE_EN || w_sub_req[CLK_DOM_RF];
  assign g_clk_pmp_req = !CLK_GATE_EN || w_sub_req[CLK_DOM_PMP];
  assign g_clk_mul_req = !CLK_GATE_EN || w_sub_req[CLK_DOM_MUL];

endmodule

// File: tb/tb_core_clock_req.sv
// Bench for core_clock_req: three configurations driven in lockstep, checked
// every cycle against a cycle-count based model, plus directed scenarios.
module tb_core_clock_req;

  logic f_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic sleep_req = 1'b0, wake_req = 1'b0;
  logic rf_act = 1'b0, pmp_act = 1'b0, mul_act = 1'b0;

  logic [2:0] o_g, o_rf, o_pmp, o_mul, o_sa, o_wa;

  int n_chk = 0;
  int n_err = 0;

  always #5 f_clk = ~f_clk;

  // 0: default, 1: gating disabled, 2: no hold-off with a longer wake
  core_clock_req u_dut (
    .f_clk(f_clk), .g_resetn(g_resetn), .sleep_req(sleep_req), .sleep_ack(o_sa[0]),
    .wake_req(wake_req), .wake_ack(o_wa[0]), .rf_act(rf_act), .pmp_act(pmp_act),
    .mul_act(mul_act), .g_clk_req(o_g[0]), .g_clk_rf_req(o_rf[0]),
    .g_clk_pmp_req(o_pmp[0]), .g_clk_mul_req(o_mul[0]));

  core_clock_req #(.CLK_GATE_EN(1'b0)) u_ng (
    .f_clk(f_clk), .g_resetn(g_resetn), .sleep_req(sleep_req), .sleep_ack(o_sa[1]),
    .wake_req(wake_req), .wake_ack(o_wa[1]), .rf_act(rf_act), .pmp_act(pmp_act),
    .mul_act(mul_act), .g_clk_req(o_g[1]), .g_clk_rf_req(o_rf[1]),
    .g_clk_pmp_req(o_pmp[1]), .g_clk_mul_req(o_mul[1]));

  core_clock_req #(.IDLE_CYCLES(0), .WAKE_CYCLES(3)) u_z (
    .f_clk(f_clk), .g_resetn(g_resetn), .sleep_req(sleep_req), .sleep_ack(o_sa[2]),
    .wake_req(wake_req), .wake_ack(o_wa[2]), .rf_act(rf_act), .pmp_act(pmp_act),
    .mul_act(mul_act), .g_clk_req(o_g[2]), .g_clk_rf_req(o_rf[2]),
    .g_clk_pmp_req(o_pmp[2]), .g_clk_mul_req(o_mul[2]));

  task automatic chk(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sub req = "activity within the last IDLE cycles" measured in cycle numbers;
  // sleep is only entered once every window has expired, so freezing needs no state.
  int  idle_p [3] = '{4, 4, 0};
  int  wake_p [3] = '{2, 2, 3};
  bit  gate_p [3] = '{1'b1, 1'b0, 1'b1};
  bit  m_sleep [3];
  bit  m_drain [3];
  bit  m_ack   [3];
  int  m_wleft [3];
  longint m_last [3][3];
  longint cyc = 0;

  always @(negedge f_clk) begin
    logic [2:0] act;
    act = {mul_act, pmp_act, rf_act};
    for (int k = 0; k < 3; k++) begin
      logic [2:0] busy, got;
      logic eg, esa, ewa;
      bit was_sleep, ack_nx;
      got = {o_mul[k], o_pmp[k], o_rf[k]};
      if (!g_resetn) begin
        for (int d = 0; d < 3; d++) busy[d] = (idle_p[k] > 0) || act[d];
        eg = 1'b1; esa = 1'b0; ewa = 1'b0;
        m_sleep[k] = 0; m_drain[k] = 0; m_ack[k] = 0; m_wleft[k] = 0;
        for (int d = 0; d < 3; d++) m_last[k][d] = cyc;
      end else begin
        for (int d = 0; d < 3; d++)
          busy[d] = !m_sleep[k] && (act[d] || ((cyc - m_last[k][d]) <= longint'(idle_p[k])));
        eg  = !m_sleep[k] || !gate_p[k];
        esa = m_sleep[k];
        ewa = m_ack[k];
        was_sleep = m_sleep[k];
        ack_nx = 0;
        if (m_sleep[k]) begin
          if (wake_req) begin m_sleep[k] = 0; m_wleft[k] = wake_p[k]; end
        end else if (m_wleft[k] > 0) begin
          m_wleft[k]--;
          if (m_wleft[k] == 0) ack_nx = 1;
        end else if (m_drain[k]) begin
          if (wake_req) m_drain[k] = 0;
          else if (busy == 3'b000) begin m_drain[k] = 0; m_sleep[k] = 1; end
        end else if (sleep_req && !wake_req && !m_ack[k]) begin
          m_drain[k] = 1;
        end
        if (!was_sleep)
          for (int d = 0; d < 3; d++) if (act[d]) m_last[k][d] = cyc;
        m_ack[k] = ack_nx;
      end
      chk($sformatf("m%0d_gclk", k), o_g[k], eg);
      chk($sformatf("m%0d_sack", k), o_sa[k], esa);
      chk($sformatf("m%0d_wack", k), o_wa[k], ewa);
      for (int d = 0; d < 3; d++)
        chk($sformatf("m%0d_sub%0d", k, d), got[d], gate_p[k] ? busy[d] : 1'b1);
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic s, input logic w, input logic r, input logic p, input logic m);
    @(posedge f_clk); #1;
    sleep_req = s; wake_req = w; rf_act = r; pmp_act = p; mul_act = m;
    @(negedge f_clk);
  endtask

  initial begin
    int pa, ps, pw;
    // reset state
    repeat (2) @(negedge f_clk);
    chk("rst_gclk", o_g[0], 1'b1);
    chk("rst_rf", o_rf[0], 1'b1);
    chk("rst_sack", o_sa[0], 1'b0);
    @(posedge f_clk); #1 g_resetn = 1'b1;
    @(negedge f_clk);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drv(0, 0, 0, 0, 0);
      chk($sformatf("rel_rf%0d", i), o_rf[0], i < 4);
      chk($sformatf("rel_mul%0d", i), o_mul[0], i < 4);
      chk($sformatf("rel_gclk%0d", i), o_g[0], 1'b1);
    end

    // hold retrigger: rf_act at 0 and 3
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, (i == 0) || (i == 3), 0, 0);
      chk($sformatf("rtg_rf%0d", i), o_rf[0], i <= 7);
      chk($sformatf("rtg_pmp%0d", i), o_pmp[0], 1'b0);
    end

    // sleep with mul counter at 2
    drv(0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drv(1, 0, i == 5, 0, 0);
      chk($sformatf("slp_gclk%0d", i), o_g[0], i < 3);
      chk($sformatf("slp_sack%0d", i), o_sa[0], i >= 3);
      if (i < 3) chk($sformatf("slp_mul%0d", i), o_mul[0], i < 2);
      else       chk($sformatf("slp_rf%0d", i), o_rf[0], 1'b0);
    end

    // wake: pulse wake_req, keep sleep_req through the wake_ack cycle
    for (int i = 0; i < 7; i++) begin
      drv(i <= 3, i == 0, 0, 0, 0);
      chk($sformatf("wk_gclk%0d", i), o_g[0], i >= 1);
      chk($sformatf("wk_sack%0d", i), o_sa[0], i == 0);
      chk($sformatf("wk_wack%0d", i), o_wa[0], i == 3);
    end

    // abort from DRAIN
    for (int i = 0; i < 9; i++) begin
      drv(i <= 2, i == 2, i == 0, 0, 0);
      chk($sformatf("abt_sack%0d", i), o_sa[0], 1'b0);
      chk($sformatf("abt_gclk%0d", i), o_g[0], 1'b1);
    end

    // async reset while asleep
    repeat (8) drv(1, 0, 0, 0, 0);
    chk("rs_pre_sack", o_sa[0], 1'b1);
    @(posedge f_clk); #1 g_resetn = 1'b0; sleep_req = 1'b0;
    #1;
    chk("rs_sack", o_sa[0], 1'b0);
    chk("rs_gclk", o_g[0], 1'b1);
    chk("rs_rf", o_rf[0], 1'b1);
    chk("rs_pmp", o_pmp[0], 1'b1);
    chk("rs_mul", o_mul[0], 1'b1);
    chk("rs_ng_gclk", o_g[1], 1'b1);
    repeat (2) @(negedge f_clk);
    @(posedge f_clk); #1 g_resetn = 1'b1;

    // randomized segments with varying activity density
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 2))
        0:       pa = 0;
        1:       pa = 5;
        default: pa = 30;
      endcase
      ps = $urandom_range(0, 100);
      pw = $urandom_range(2, 15);
      for (int i = 0; i < 60; i++) begin
        @(posedge f_clk); #1;
        g_resetn  = ($urandom_range(0, 499) != 0);
        sleep_req = ($urandom_range(0, 99) < ps);
        wake_req  = ($urandom_range(0, 99) < pw);
        rf_act    = ($urandom_range(0, 99) < pa);
        pmp_act   = ($urandom_range(0, 99) < pa);
        mul_act   = ($urandom_range(0, 99) < pa);
      end
    end

    drv(0, 0, 0, 0, 0);
    @(negedge f_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
